// File: rtl/neuron_activation_pkg.sv
// Shared constants, activation-type encoding and the sigmoid table generator for neuron_activation.
// The table generator serves both the full ROM and the ACT_HALF_ROM_EN half ROM.
package neuron_activation_pkg;

    localparam int DEF_DATA_WIDTH       = 16;
    localparam int DEF_WEIGHT_INT_WIDTH = 4;
    localparam int DEF_SIGMOID_SIZE     = 10;

    typedef enum logic {
        ACT_RELU    = 1'b0,
        ACT_SIGMOID = 1'b1
    } act_type_e;

    // round(2^out_bits / (1 + e^-v)) with v = x / 2^frac_bits, evaluated in Q60 integer arithmetic.
    // e^-h for one LSB comes from a Taylor series; e^-|v| is built from repeated squares of it.
    function automatic int sigmoid_entry(input int x, input int frac_bits,
                                         input int addr_bits, input int out_bits);
        logic [127:0] one;
        logic [127:0] term;
        logic [127:0] ex;
        logic [127:0] p;
        logic [127:0] acc;
        logic [127:0] num;
        logic [127:0] den;
        logic [127:0] res;
        logic [127:0] lim;
        int           mag;
        logic         neg;
        one  = 128'd1 << 60;
        term = one;
        ex   = one;
        for (int n = 1; n < 24; n++) begin
            term = (term >> frac_bits) / 128'(n);
            if (n % 2 == 1) ex = ex - term;
            else            ex = ex + term;
        end
        neg = (x < 0);
        mag = neg ? -x : x;
        p   = ex;
        acc = one;
        for (int k = 0; k < addr_bits; k++) begin
            if (mag[k]) acc = (acc * p) >> 60;
            p = (p * p) >> 60;
        end
        den = one + acc;
        num = (neg ? acc : one) << out_bits;
        res = (128'd2 * num + den) / (128'd2 * den);
        lim = (128'd1 << out_bits) - 128'd1;
        if (res > lim) res = lim;
        return int'(res[31:0]);
    endfunction

endpackage

// File: rtl/neuron_activation_sigmoid_rom.sv
// sigmoid_rom: saturates the accumulator to a SIGMOID_SIZE-bit address and looks up the sigmoid.
// Defining ACT_HALF_ROM_EN builds a half-size table and mirrors negative inputs by symmetry.
module sigmoid_rom
    import neuron_activation_pkg::*;
#(
    parameter int DATA_WIDTH       = DEF_DATA_WIDTH,
    parameter int WEIGHT_INT_WIDTH = DEF_WEIGHT_INT_WIDTH,
    parameter int SIGMOID_SIZE     = DEF_SIGMOID_SIZE
) (
    input  logic [2*DATA_WIDTH-1:0] sum,
    output logic [DATA_WIDTH-1:0]   sig_out
);

    localparam int SUM_W    = 2 * DATA_WIDTH;
    localparam int SHIFT    = SUM_W - WEIGHT_INT_WIDTH - SIGMOID_SIZE;
    localparam int FRAC     = SIGMOID_SIZE - WEIGHT_INT_WIDTH;
    localparam int OUT_BITS = DATA_WIDTH - 1;
    localparam logic [SIGMOID_SIZE-1:0] X_MAX = {1'b0, {(SIGMOID_SIZE-1){1'b1}}};
    localparam logic [SIGMOID_SIZE-1:0] X_MIN = {1'b1, {(SIGMOID_SIZE-1){1'b0}}};

    logic [SUM_W-1:0]        shifted_s;
    logic [SIGMOID_SIZE-1:0] x_s;
    logic                    sign_s;
    logic                    over_s;

    assign shifted_s = $signed(sum) >>> SHIFT;

    // Clamp to the signed address range: every bit above the address MSB must copy the sign
    always_comb begin
        sign_s = shifted_s[SUM_W-1];
        if (sign_s) over_s = ~&shifted_s[SUM_W-1:SIGMOID_SIZE-1];
        else        over_s = |shifted_s[SUM_W-1:SIGMOID_SIZE-1];
        if (!over_s)     x_s = shifted_s[SIGMOID_SIZE-1:0];
        else if (sign_s) x_s = X_MIN;
        else             x_s = X_MAX;
    end

`ifdef ACT_HALF_ROM_EN
    localparam int DEPTH = 2 ** (SIGMOID_SIZE - 1);
    localparam logic [DATA_WIDTH-1:0] ONE_HALF_SCALE = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    logic [DATA_WIDTH-1:0]   rom_s [DEPTH];
    logic [SIGMOID_SIZE-2:0] addr_s;
    logic [SIGMOID_SIZE-1:0] neg_x_s;

    for (genvar i = 0; i < DEPTH; i++) begin : g_rom
        localparam logic [DATA_WIDTH-1:0] ENTRY =
            DATA_WIDTH'(sigmoid_entry(i, FRAC, SIGMOID_SIZE, OUT_BITS));
        assign rom_s[i] = ENTRY;
    end

    // Negative inputs read sigmoid(|x|) and return 1 - entry; -X_MIN does not fit and clamps
    always_comb begin
        neg_x_s = -x_s;
        if (!x_s[SIGMOID_SIZE-1]) begin
            addr_s  = x_s[SIGMOID_SIZE-2:0];
            sig_out = rom_s[addr_s];
        end else begin
            if (neg_x_s[SIGMOID_SIZE-1]) addr_s = {(SIGMOID_SIZE-1){1'b1}};
            else                         addr_s = neg_x_s[SIGMOID_SIZE-2:0];
            sig_out = ONE_HALF_SCALE - rom_s[addr_s];
        end
    end
`else
    localparam int DEPTH = 2 ** SIGMOID_SIZE;

    logic [DATA_WIDTH-1:0]   rom_s [DEPTH];
    logic [SIGMOID_SIZE-1:0] addr_s;

    for (genvar i = 0; i < DEPTH; i++) begin : g_rom
        localparam logic [DATA_WIDTH-1:0] ENTRY =
            DATA_WIDTH'(sigmoid_entry(i - DEPTH / 2, FRAC, SIGMOID_SIZE, OUT_BITS));
        assign rom_s[i] = ENTRY;
    end

    // Offset-binary address: x + 2^(SIGMOID_SIZE-1) is x with its sign bit inverted
    always_comb begin
        addr_s  = {~x_s[SIGMOID_SIZE-1], x_s[SIGMOID_SIZE-2:0]};
        sig_out = rom_s[addr_s];
    end
`endif

endmodule

// File: rtl/neuron_activation.sv
// neuron_activation: registered ReLU-with-saturation or sigmoid-ROM stage, one cycle of latency.
// Sigmoid table layout follows ACT_HALF_ROM_EN (see sigmoid_rom); ReLU is unaffected.
module neuron_activation
    import neuron_activation_pkg::*;
#(
    parameter int    DATA_WIDTH       = DEF_DATA_WIDTH,
    parameter int    WEIGHT_INT_WIDTH = DEF_WEIGHT_INT_WIDTH,
    parameter int    SIGMOID_SIZE     = DEF_SIGMOID_SIZE,
    parameter string ACT_TYPE         = "sigmoid"
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic [2*DATA_WIDTH-1:0] sum,
    output logic [DATA_WIDTH-1:0]   out,
    output logic                    out_valid
);

    localparam int SUM_W = 2 * DATA_WIDTH;
    localparam int S     = SUM_W - 1 - WEIGHT_INT_WIDTH;
    localparam act_type_e ACT_SEL = (ACT_TYPE == "sigmoid") ? ACT_SIGMOID : ACT_RELU;

    logic [DATA_WIDTH-1:0] act_s;
    logic [DATA_WIDTH-1:0] out_d;
    logic [DATA_WIDTH-1:0] out_q;
    logic                  out_valid_d;
    logic                  out_valid_q;

    if (ACT_SEL == ACT_SIGMOID) begin : g_sigmoid
        sigmoid_rom #(
            .DATA_WIDTH       (DATA_WIDTH),
            .WEIGHT_INT_WIDTH (WEIGHT_INT_WIDTH),
            .SIGMOID_SIZE     (SIGMOID_SIZE)
        ) u_sigmoid_rom (
            .sum     (sum),
            .sig_out (act_s)
        );
    end else begin : g_relu
        localparam logic [DATA_WIDTH-1:0] RELU_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};

        // Negative clamps to zero; any integer bit above the output window saturates
        always_comb begin
            if (sum[SUM_W-1])          act_s = {DATA_WIDTH{1'b0}};
            else if (|sum[SUM_W-2:S])  act_s = RELU_MAX;
            else                       act_s = sum[S -: DATA_WIDTH];
        end
    end

    // Next-state: capture only on a strobe, valid is a straight delay
    always_comb begin
        out_valid_d = in_valid;
        if (in_valid) out_d = act_s;
        else          out_d = out_q;
    end

    // Output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_q       <= {DATA_WIDTH{1'b0}};
            out_valid_q <= 1'b0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_neuron_activation.sv
// Self-checking bench for neuron_activation: sigmoid and ReLU instances share one stimulus stream.
module tb_neuron_activation;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] sum;
    logic [15:0] out_sig;
    logic [15:0] out_relu;
    logic        ov_sig;
    logic        ov_relu;

    always #5 clk = ~clk;

    neuron_activation #(.ACT_TYPE("sigmoid")) dut_sig (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .sum       (sum),
        .out       (out_sig),
        .out_valid (ov_sig)
    );

    neuron_activation #(.ACT_TYPE("relu")) dut_relu (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .sum       (sum),
        .out       (out_relu),
        .out_valid (ov_relu)
    );

    typedef struct {
        logic [31:0] sum;
        logic [15:0] relu_exp;
        logic [15:0] sig_exp;
        bit          use_model;
    } vec_t;

    typedef struct {
        int          cyc;
        logic [15:0] relu_exp;
        logic [15:0] sig_exp;
        int          sig_tol;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    vec_t        vecs[12];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    logic [15:0] held_relu = 16'd0;
    logic [15:0] held_sig = 16'd0;
    int          held_tol = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int sat_x(input logic [31:0] s);
        int t;
        t = $signed(s) >>> 18;
        if (t > 511)  return 511;
        if (t < -512) return -512;
        return t;
    endfunction

    function automatic int sig_model(input int x);
        real v;
        real r;
        v = real'(x) / 64.0;
        r = 32768.0 / (1.0 + $exp(-v));
        return $rtoi(r + 0.5);
    endfunction

    function automatic logic [15:0] relu_model(input logic [31:0] s);
        if (s[31])         return 16'h0000;
        if (|s[30:27])     return 16'h7FFF;
        return s[27:12];
    endfunction

    task automatic check(input string name, input int act, input int req, input int tol);
        int d;
        n_cmp++;
        d = act - req;
        if (d < 0) d = -d;
        if (d > tol) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (tolerance %0d) at cycle %0d",
                     name, act, req, tol, cyc);
        end
    endtask

    // Scoreboard: each strobe is due exactly one cycle later; otherwise outputs must hold
    always @(negedge clk) begin
        bit ev;
        while (q.size() > 0 && q[0].cyc + 1 < cyc) begin
            mon_e = q.pop_front();
            check("stale_entry", 0, 1, 0);
        end
        ev = (q.size() > 0) && (q[0].cyc + 1 == cyc);
        check("out_valid_sig", int'(ov_sig), int'(ev), 0);
        check("out_valid_relu", int'(ov_relu), int'(ev), 0);
        if (ev) begin
            mon_e = q.pop_front();
            check("sig_out", int'(out_sig), int'(mon_e.sig_exp), mon_e.sig_tol);
            check("relu_out", int'(out_relu), int'(mon_e.relu_exp), 0);
            held_sig  = mon_e.sig_exp;
            held_relu = mon_e.relu_exp;
            held_tol  = mon_e.sig_tol;
        end else begin
            check("hold_sig", int'(out_sig), int'(held_sig), held_tol);
            check("hold_relu", int'(out_relu), int'(held_relu), 0);
        end
    end

    task automatic drive(input logic [31:0] s, input logic [15:0] r_exp,
                         input logic [15:0] s_exp, input int tol);
        exp_t e;
        @(negedge clk);
        #1;
        in_valid = 1'b1;
        sum      = s;
        if (rst) begin
            e.cyc      = cyc;
            e.relu_exp = r_exp;
            e.sig_exp  = s_exp;
            e.sig_tol  = tol;
            q.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
            in_valid = 1'b0;
            sum      = $urandom;
        end
    endtask

    task automatic drive_vec(input vec_t v);
        if (v.use_model) drive(v.sum, v.relu_exp, 16'(sig_model(sat_x(v.sum))), 1);
        else             drive(v.sum, v.relu_exp, v.sig_exp, 0);
    endtask

    initial begin
        vecs[0]  = '{32'h0000_1000, 16'h0001, 16'd16384, 1'b0};
        vecs[1]  = '{32'h0800_0000, 16'h7FFF, 16'd32757, 1'b0};
        vecs[2]  = '{32'h8000_0000, 16'h0000, 16'd11,    1'b0};
        vecs[3]  = '{32'h0000_0000, 16'h0000, 16'd16384, 1'b0};
        vecs[4]  = '{32'h0100_0000, 16'h1000, 16'd23955, 1'b0};
        vecs[5]  = '{32'hFF00_0000, 16'h0000, 16'd8813,  1'b0};
        vecs[6]  = '{32'h7FFF_FFFF, 16'h7FFF, 16'd32757, 1'b0};
        vecs[7]  = '{32'h07FF_FFFF, 16'h7FFF, 16'd32757, 1'b0};
        vecs[8]  = '{32'h00AB_C000, 16'h0ABC, 16'd0,     1'b1};
        vecs[9]  = '{32'hFFF4_0000, 16'h0000, 16'd0,     1'b1};
        vecs[10] = '{32'h4000_0000, 16'h7FFF, 16'd32757, 1'b0};
        vecs[11] = '{32'hC000_0000, 16'h0000, 16'd11,    1'b0};

        rst      = 1'b0;
        in_valid = 1'b0;
        sum      = 32'd0;
        #2;
        check("reset_out_sig", int'(out_sig), 0, 0);
        check("reset_out_relu", int'(out_relu), 0, 0);
        check("reset_valid_sig", int'(ov_sig), 0, 0);
        check("reset_valid_relu", int'(ov_relu), 0, 0);
        #21;
        rst = 1'b1;

        // Table vectors back-to-back (streaming), then idle cycles that must hold
        for (int i = 0; i < 12; i++) drive_vec(vecs[i]);
        idle(3);

        // Isolated strobes separated by gaps
        drive_vec(vecs[4]);
        idle(2);
        drive_vec(vecs[5]);
        idle(2);

        // Reset asserted mid-stream, with a strobe presented on the reset cycle
        drive_vec(vecs[0]);
        drive_vec(vecs[1]);
        @(negedge clk);
        #1;
        in_valid = 1'b1;
        sum      = 32'h0100_0000;
        #1;
        rst = 1'b0;
        q.delete();
        held_sig  = 16'd0;
        held_relu = 16'd0;
        held_tol  = 0;
        #1;
        check("midreset_out_sig", int'(out_sig), 0, 0);
        check("midreset_out_relu", int'(out_relu), 0, 0);
        check("midreset_valid_sig", int'(ov_sig), 0, 0);
        check("midreset_valid_relu", int'(ov_relu), 0, 0);
        @(negedge clk);
        #1;
        in_valid = 1'b0;
        rst      = 1'b1;
        idle(1);
        drive_vec(vecs[5]);
        idle(2);

        // Sweep every sigmoid address against a real-valued model; low bits are noise
        for (int x = -512; x < 512; x++) begin
            logic [31:0] s;
            s = (32'(x) << 18) | 32'($urandom_range(0, 262143));
            drive(s, relu_model(s), 16'(sig_model(x)), 1);
        end
        idle(3);

        check("queue_drained", q.size(), 0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
